// File: rtl/pspin_her_buf.sv
// rtl/pspin_her_buf.sv - FWFT HER buffer between the HER generator and PsPIN with in-flight throttling
module pspin_her_buf #(
    parameter int unsigned C_MSGID_WIDTH  = 10,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned META_WIDTH     = 640,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned MAX_INFLIGHT   = 16,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                              clk,
    input  logic                              rstn,

    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [C_MSGID_WIDTH-1:0]          in_msgid,
    input  logic                              in_is_eom,
    input  logic [AXI_ADDR_WIDTH-1:0]         in_addr,
    input  logic [AXI_ADDR_WIDTH-1:0]         in_size,
    input  logic [AXI_ADDR_WIDTH-1:0]         in_xfer_size,
    input  logic [META_WIDTH-1:0]             in_meta,

    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [C_MSGID_WIDTH-1:0]          out_msgid,
    output logic                              out_is_eom,
    output logic [AXI_ADDR_WIDTH-1:0]         out_addr,
    output logic [AXI_ADDR_WIDTH-1:0]         out_size,
    output logic [AXI_ADDR_WIDTH-1:0]         out_xfer_size,
    output logic [META_WIDTH-1:0]             out_meta,

    input  logic                              fb_valid,

    output logic [$clog2(DEPTH):0]            stat_occupancy,
    output logic [$clog2(MAX_INFLIGHT):0]     stat_inflight,
    output logic [CNT_WIDTH-1:0]              stat_dispatched,
    output logic [CNT_WIDTH-1:0]              stat_dropped,
    output logic                              err_fb_underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned IW = $clog2(MAX_INFLIGHT);
    localparam int unsigned EW = C_MSGID_WIDTH + 1 + 3 * AXI_ADDR_WIDTH + META_WIDTH;

    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0] TWO_C   = (PW+1)'(2);
    localparam logic [IW:0] MAXI_C  = (IW+1)'(MAX_INFLIGHT);

    logic [EW-1:0]        mem_q [DEPTH];
    logic [PW:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [IW:0]          inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] disp_q, disp_d, drop_q, drop_d;
    logic                 err_q, err_d;

    logic [PW:0]          count;
    logic                 full, push, pop, drop;
    logic [EW-1:0]        in_entry, head;

    assign in_entry = {in_msgid, in_is_eom, in_addr, in_size, in_xfer_size, in_meta};
    assign head     = mem_q[rptr_q[PW-1:0]];
    assign {out_msgid, out_is_eom, out_addr, out_size, out_xfer_size, out_meta} = head;

    always_comb begin
        count     = wptr_q - rptr_q;
        full      = (count == DEPTH_C);
        // two free slots: covers a push launched the cycle before in_ready fell
        in_ready  = (DEPTH_C - count) >= TWO_C;
        out_valid = (count != '0) && (inflight_q < MAXI_C);
        pop       = out_valid && out_ready;
        // a same-cycle pop frees the slot, so a full FIFO still accepts
        push      = in_valid && (!full || pop);
        drop      = in_valid && full && !pop;
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        inflight_d = inflight_q;
        disp_d     = disp_q;
        drop_d     = drop_q;
        err_d      = err_q;

        if (push) wptr_d = wptr_q + 1'b1;
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
            disp_d = disp_q + 1'b1;
        end
        if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;

        if (pop && !fb_valid) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!pop && fb_valid) begin
            if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
            else                  err_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= '0;
            disp_q     <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            disp_q     <= disp_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && push) mem_q[wptr_q[PW-1:0]] <= in_entry;
    end

    assign stat_occupancy   = count;
    assign stat_inflight    = inflight_q;
    assign stat_dispatched  = disp_q;
    assign stat_dropped     = drop_q;
    assign err_fb_underflow = err_q;

endmodule

// File: doc/pspin_her_buf.md
Name: pspin_her_buf

Overview:
- Sits directly downstream of the HER generator and upstream of the PsPIN HER input.
- Buffers generated HERs in a first-word-fall-through FIFO.
- Limits the number of HERs outstanding inside PsPIN using feedback completions.
- Exposes occupancy, in-flight and dispatch statistics to the control registers.

Parameters:
- C_MSGID_WIDTH, 10, message id width.
- AXI_ADDR_WIDTH, 32, width of addr/size/xfer_size fields.
- META_WIDTH, 640, packed handler-context metadata width, carried opaquely.
- DEPTH, 8, FIFO entries; power of 2, >= 4.
- MAX_INFLIGHT, 16, maximum HERs dispatched without feedback; >= 1.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  HER from generator.
- in_ready  out  1  space available; the generator may present in_valid one cycle after sampling it high.
- in_msgid  in  C_MSGID_WIDTH  message id.
- in_is_eom  in  1  end of message.
- in_addr  in  AXI_ADDR_WIDTH  packet L2 address.
- in_size  in  AXI_ADDR_WIDTH  packet size.
- in_xfer_size  in  AXI_ADDR_WIDTH  transfer size.
- in_meta  in  META_WIDTH  packed execution-context metadata.
- out_valid  out  1  HER to PsPIN.
- out_ready  in  1  PsPIN accepts.
- out_msgid, out_is_eom, out_addr, out_size, out_xfer_size, out_meta  out  same widths as the matching in_ fields  head-entry fields.
- fb_valid  in  1  one-cycle pulse: PsPIN finished one HER.
- stat_occupancy  out  $clog2(DEPTH)+1  FIFO entries held.
- stat_inflight  out  $clog2(MAX_INFLIGHT)+1  HERs dispatched but not yet fed back.
- stat_dispatched  out  CNT_WIDTH  total HERs dispatched, wraps modulo 2^CNT_WIDTH.
- stat_dropped  out  CNT_WIDTH  HERs dropped because the FIFO was full, saturates at all-ones.
- err_fb_underflow  out  1  sticky: fb_valid received while inflight == 0.

Behaviour:
- Reset (rstn low at posedge):
  - FIFO emptied, pointers 0.
  - All stat counters 0; err_fb_underflow 0.
  - out_valid 0; in_ready 1 after reset.
  - Out data fields don't-care while out_valid = 0.
  - Reset mid-operation discards all buffered entries and zeroes inflight; no HER is emitted on the cycle after reset.
- Storage:
  - Entry = {msgid, is_eom, addr, size, xfer_size, meta}.
  - Write and read pointers are $clog2(DEPTH)+1 bits with wrap bit; count = wptr - rptr.
- in_ready:
  - Combinational: in_ready = (DEPTH - count) >= 2.
  - Guarantees room for a push already launched in the previous cycle.
- Push:
  - On in_valid && count < DEPTH (in_ready not consulted), the entry is written at wptr and wptr increments.
  - in_valid with count == DEPTH (and no pop this cycle): entry dropped, stat_dropped += 1 (saturating), state otherwise unchanged.
- Pop:
  - out_valid = (count != 0) && (inflight < MAX_INFLIGHT).
  - Out fields come combinationally from the entry at rptr (FWFT), so latency is 1 cycle from push to out_valid.
  - On out_valid && out_ready: rptr += 1, inflight += 1, stat_dispatched += 1.
  - out_valid must stay asserted and fields stable until accepted; they change only on pop, reset, or the empty -> non-empty transition.
- Simultaneous push and pop:
  - Both occur; count unchanged.
  - At count == DEPTH, a push with a same-cycle pop is accepted, not dropped.
- Feedback:
  - fb_valid && inflight > 0: inflight -= 1.
  - Pop and fb_valid in the same cycle: inflight unchanged.
  - fb_valid at inflight == 0 with no same-cycle pop: ignored, err_fb_underflow set (cleared only by reset).
  - fb_valid at inflight == 0 with a same-cycle pop: net unchanged (0), no error.
- Throttling: at inflight == MAX_INFLIGHT, out_valid is forced to 0 even with entries queued. A fb_valid in cycle t allows out_valid in cycle t+1.
- Throughput: one push and one pop per cycle sustained when MAX_INFLIGHT is not reached.

Test Plan (DEPTH=4, MAX_INFLIGHT=2 unless noted):
- Reset, then push msgid=5, addr=0x1000, size=64, is_eom=1 with out_ready=1 -> out_valid high the next cycle with identical fields; stat_dispatched=1; stat_inflight=1.
- out_ready=0, push 4 HERs back-to-back (msgid 1..4) -> in_ready drops after the 3rd push (count=3); all 4 stored; a 5th push -> stat_dropped=1; then out_ready=1 -> msgids 1,2 emitted in order, then stall at inflight=2.
- From that stalled state, pulse fb_valid once -> msgid 3 emitted the next cycle; inflight stays 2 and occupancy goes to 1.
- Full FIFO (count=4), inflight=0, out_ready=1, push at the same cycle as a pop -> no drop; occupancy stays 4; order preserved.
- fb_valid with inflight=0 -> err_fb_underflow=1, inflight stays 0; same-cycle pop + fb_valid at inflight=1 -> inflight stays 1.
- Assert rstn low with 3 entries buffered and inflight=2 -> next cycle out_valid=0, occupancy=0, inflight=0, all stats 0, in_ready=1.
